// File: rtl/class_hv_bank_if.sv
// class_hv_bank_if: write/read/flag bundle for the class HV bank.
// PRUNE_MASK_EN adds the pruning-mask write port.
interface class_hv_bank_if #(
  parameter int NUM_CLASSES     = 26,
  parameter int DIMS_PER_CC     = 1024,
  parameter int SEQ_CYCLE_COUNT = 4
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int SEG_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;

  logic                   wr_start;
  logic [CLS_W-1:0]       wr_class;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [DIMS_PER_CC-1:0] wr_data;
  logic                   wr_done;
  logic                   wr_err;
  logic                   clear_valid;
  logic                   rd_en;
  logic [CLS_W-1:0]       rd_class;
  logic [SEG_W-1:0]       rd_seg;
  logic                   rd_valid;
  logic [DIMS_PER_CC-1:0] rd_data;
  logic [NUM_CLASSES-1:0] class_valid;
`ifdef PRUNE_MASK_EN
  logic                   mask_we;
  logic [SEG_W-1:0]       mask_seg;
  logic [DIMS_PER_CC-1:0] mask_data;
`endif

  modport slave (
    input  wr_start, wr_class, wr_valid, wr_data,
    input  clear_valid, rd_en, rd_class, rd_seg,
`ifdef PRUNE_MASK_EN
    input  mask_we, mask_seg, mask_data,
`endif
    output wr_ready, wr_done, wr_err,
    output rd_valid, rd_data, class_valid
  );

  modport master (
    output wr_start, wr_class, wr_valid, wr_data,
    output clear_valid, rd_en, rd_class, rd_seg,
`ifdef PRUNE_MASK_EN
    output mask_we, mask_seg, mask_data,
`endif
    input  wr_ready, wr_done, wr_err,
    input  rd_valid, rd_data, class_valid
  );
endinterface

// File: rtl/class_hv_bank.sv
// class_hv_bank: per-class binarized HV store, segment-wise fill, registered read.
// Optional PRUNE_MASK_EN: per-segment AND mask applied on read-back.
module class_hv_bank #(
  parameter int NUM_CLASSES     = 26,
  parameter int DIMS_PER_CC     = 1024,
  parameter int SEQ_CYCLE_COUNT = 4
) (
  input logic             clk,
  input logic             rst,
  class_hv_bank_if.slave  bus
);
  localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int SEG_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEQ_CYCLE_COUNT - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                 state_q, state_d;
  logic [CLS_W-1:0]       cls_q;
  logic [SEG_W-1:0]       seg_q;
  logic [DIMS_PER_CC-1:0] store [NUM_CLASSES][SEQ_CYCLE_COUNT];
  logic [NUM_CLASSES-1:0] flags_q;
  logic                   done_q, err_q, rv_q;
  logic [DIMS_PER_CC-1:0] rd_q;
  logic                   xfer, last, start_ok, done_d, err_d;
  logic                   rd_hit;
  logic [DIMS_PER_CC-1:0] rd_word;

`ifdef PRUNE_MASK_EN
  logic [DIMS_PER_CC-1:0] mask_q [SEQ_CYCLE_COUNT];
`endif

  // next-state, transfer and error/done decode
  always_comb begin
    state_d  = state_q;
    xfer     = 1'b0;
    last     = 1'b0;
    start_ok = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_start) begin
          if (int'(bus.wr_class) < NUM_CLASSES) begin
            start_ok = 1'b1;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        err_d = bus.wr_start;
        xfer  = bus.wr_valid;
        last  = bus.wr_valid && (seg_q == SEG_LAST);
        if (last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched class, segment counter, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cls_q   <= '0;
      seg_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (start_ok) begin
        cls_q <= bus.wr_class;
        seg_q <= '0;
      end else if (xfer) begin
        seg_q <= last ? '0 : seg_q + SEG_W'(1);
      end
    end
  end

  // HV storage: cleared on reset, one segment written per transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++)
        for (int s = 0; s < SEQ_CYCLE_COUNT; s++)
          store[c][s] <= '0;
    end else if (xfer) begin
      store[cls_q][seg_q] <= bus.wr_data;
    end
  end

  // per-class valid flags; a completing load beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      if (bus.clear_valid) flags_q <= '0;
      if (start_ok) flags_q[bus.wr_class] <= 1'b0;
      if (last) flags_q[cls_q] <= 1'b1;
    end
  end

`ifdef PRUNE_MASK_EN
  // pruning mask, all dimensions kept after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SEQ_CYCLE_COUNT; s++)
        mask_q[s] <= '1;
    end else if (bus.mask_we && int'(bus.mask_seg) < SEQ_CYCLE_COUNT) begin
      mask_q[bus.mask_seg] <= bus.mask_data;
    end
  end
`endif

  // read word select with range guard
  always_comb begin
    rd_hit  = (int'(bus.rd_class) < NUM_CLASSES) &&
              (int'(bus.rd_seg) < SEQ_CYCLE_COUNT);
    rd_word = '0;
    if (rd_hit) begin
`ifdef PRUNE_MASK_EN
      rd_word = store[bus.rd_class][bus.rd_seg] & mask_q[bus.rd_seg];
`else
      rd_word = store[bus.rd_class][bus.rd_seg];
`endif
    end
  end

  // registered read port; data holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q <= 1'b0;
      rd_q <= '0;
    end else begin
      rv_q <= bus.rd_en;
      if (bus.rd_en) rd_q <= rd_word;
    end
  end

  assign bus.wr_ready    = (state_q == LOAD);
  assign bus.wr_done     = done_q;
  assign bus.wr_err      = err_q;
  assign bus.rd_valid    = rv_q;
  assign bus.rd_data     = rd_q;
  assign bus.class_valid = flags_q;
endmodule

// File: tb/tb_class_hv_bank.sv
// tb_class_hv_bank: directed stimulus, behavioural model, per-cycle compare.
// Build with PRUNE_MASK_EN to exercise the pruning mask.
module tb_class_hv_bank;
  localparam int NC = 26;
  localparam int DW = 1024;
  localparam int NS = 4;

  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  class_hv_bank_if bus ();

  class_hv_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  word_t PA5, P0F, PFF, P01, PMK;

  // model state
  word_t       m_store [NC][NS];
  word_t       m_mask  [NS];
  logic [NC-1:0] m_valid;
  bit          m_busy;
  int          m_cls, m_seg;
  bit          e_done, e_err, e_rv;
  word_t       e_rd;
  bit          started = 0;

  task automatic chk(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (low 64 bits)", name,
               got[63:0], exp[63:0]);
    end
  endtask

  // model: applies the bank's rules to each sampled input cycle
  always @(posedge clk) begin
    logic [NC-1:0] nv;
    int rc, rs;
    if (rst) begin
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < NS; s++) m_store[c][s] = '0;
      for (int s = 0; s < NS; s++) m_mask[s] = '1;
      m_valid = '0; m_busy = 0; m_cls = 0; m_seg = 0;
      e_done = 0; e_err = 0; e_rv = 0; e_rd = '0;
    end else begin
      rc = int'(bus.rd_class);
      rs = int'(bus.rd_seg);
      e_rv = bus.rd_en;
      if (bus.rd_en) begin
        if (rc < NC && rs < NS) begin
`ifdef PRUNE_MASK_EN
          e_rd = m_store[rc][rs] & m_mask[rs];
`else
          e_rd = m_store[rc][rs];
`endif
        end else begin
          e_rd = '0;
        end
      end
      e_done = 0;
      e_err  = 0;
      nv = bus.clear_valid ? '0 : m_valid;
      if (m_busy) begin
        if (bus.wr_start) e_err = 1;
        if (bus.wr_valid) begin
          m_store[m_cls][m_seg] = bus.wr_data;
          if (m_seg == NS - 1) begin
            nv[m_cls] = 1'b1;
            e_done = 1;
            m_busy = 0;
            m_seg  = 0;
          end else begin
            m_seg++;
          end
        end
      end else if (bus.wr_start) begin
        if (int'(bus.wr_class) < NC) begin
          m_busy = 1;
          m_cls  = int'(bus.wr_class);
          m_seg  = 0;
          nv[m_cls] = 1'b0;
        end else begin
          e_err = 1;
        end
      end
      m_valid = nv;
`ifdef PRUNE_MASK_EN
      if (bus.mask_we && int'(bus.mask_seg) < NS)
        m_mask[bus.mask_seg] = bus.mask_data;
`endif
    end
    started = 1;
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("m_wr_ready", word_t'(bus.wr_ready), word_t'(m_busy));
      chk("m_wr_done", word_t'(bus.wr_done), word_t'(e_done));
      chk("m_wr_err", word_t'(bus.wr_err), word_t'(e_err));
      chk("m_rd_valid", word_t'(bus.rd_valid), word_t'(e_rv));
      chk("m_rd_data", bus.rd_data, e_rd);
      chk("m_class_valid", word_t'(bus.class_valid), word_t'(m_valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int c, input word_t d0, input word_t d1,
                      input word_t d2, input word_t d3, input bit stall);
    word_t d [NS];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bus.wr_start = 1'b1;
    bus.wr_class = 5'(c);
    tick();
    bus.wr_start = 1'b0;
    for (int s = 0; s < NS; s++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = d[s];
      tick();
      if (stall && s < NS - 1) begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = ~d[s];
        tick();
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input int c, input int s);
    bus.rd_en    = 1'b1;
    bus.rd_class = 5'(c);
    bus.rd_seg   = 2'(s);
    tick();
    bus.rd_en    = 1'b0;
  endtask

  initial begin
    word_t pat [NS];
    PA5 = {128{8'hA5}};
    P0F = {128{8'h0F}};
    PFF = '1;
    P01 = word_t'(1);
    PMK = {32{32'h0000FFFF}};
    pat[0] = PA5; pat[1] = P0F; pat[2] = PFF; pat[3] = P01;

    bus.wr_start = 0; bus.wr_class = '0; bus.wr_valid = 0;
    bus.wr_data = '0; bus.clear_valid = 0; bus.rd_en = 0;
    bus.rd_class = '0; bus.rd_seg = '0;
`ifdef PRUNE_MASK_EN
    bus.mask_we = 0; bus.mask_seg = '0; bus.mask_data = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_class_valid", word_t'(bus.class_valid), '0);
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_wr_ready", word_t'(bus.wr_ready), '0);

    // class 3, no stalls
    load(3, PA5, P0F, PFF, P01, 0);
    chk("c3_done", word_t'(bus.wr_done), word_t'(1));
    chk("c3_valid", word_t'(bus.class_valid), word_t'(26'h0000008));
    for (int s = 0; s < NS; s++) begin
      rd(3, s);
      chk("c3_read", bus.rd_data, pat[s]);
    end

    // class 25, wr_valid toggling
    load(25, P01, PFF, P0F, PA5, 1);
    chk("c25_done", word_t'(bus.wr_done), word_t'(1));
    chk("c25_valid", word_t'(bus.class_valid), word_t'(26'h2000008));
    rd(25, 2);
    chk("c25_read2", bus.rd_data, P0F);
    rd(3, 1);
    chk("c3_intact", bus.rd_data, P0F);

    // rejected starts
    bus.wr_start = 1'b1;
    bus.wr_class = 5'd26;
    tick();
    bus.wr_start = 1'b0;
    chk("err_range", word_t'(bus.wr_err), word_t'(1));
    chk("err_idle", word_t'(bus.wr_ready), '0);
    bus.wr_start = 1'b1;
    bus.wr_class = 5'd2;
    tick();
    bus.wr_class = 5'd1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = PA5;
    tick();
    bus.wr_start = 1'b0;
    chk("err_busy", word_t'(bus.wr_err), word_t'(1));
    // same-cycle read/write of (2,1)
    bus.wr_data  = PFF;
    bus.rd_en    = 1'b1;
    bus.rd_class = 5'd2;
    bus.rd_seg   = 2'd1;
    tick();
    chk("rw_old", bus.rd_data, '0);
    bus.wr_data = P0F;
    tick();
    chk("rw_new", bus.rd_data, PFF);
    bus.rd_en   = 1'b0;
    bus.wr_data = P01;
    tick();
    bus.wr_valid = 1'b0;
    chk("c2_done", word_t'(bus.wr_done), word_t'(1));
    chk("c2_valid", word_t'(bus.class_valid), word_t'(26'h200000C));

    // out-of-range read, then rd_en low holds data
    rd(3, 0);
    rd(30, 0);
    chk("oor_data", bus.rd_data, '0);
    chk("oor_valid", word_t'(bus.rd_valid), word_t'(1));
    rd(3, 0);
    tick();
    chk("hold_data", bus.rd_data, PA5);
    chk("hold_valid", word_t'(bus.rd_valid), '0);

    // reset in the middle of class 7
    bus.wr_start = 1'b1;
    bus.wr_class = 5'd7;
    tick();
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = PFF;
    tick();
    tick();
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", word_t'(bus.class_valid), '0);
    chk("mid_rst_ready", word_t'(bus.wr_ready), '0);
    rd(3, 0);
    chk("mid_rst_store", bus.rd_data, '0);
    rd(7, 0);
    chk("mid_rst_c7", bus.rd_data, '0);

    // clear_valid together with a final transfer
    load(5, P01, P01, P01, P01, 0);
    chk("c5_valid", word_t'(bus.class_valid), word_t'(26'h0000020));
    bus.wr_start = 1'b1;
    bus.wr_class = 5'd4;
    tick();
    bus.wr_start = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = PA5;
    tick();
    tick();
    tick();
    bus.clear_valid = 1'b1;
    tick();
    bus.clear_valid = 1'b0;
    bus.wr_valid    = 1'b0;
    chk("clr_set_wins", word_t'(bus.class_valid), word_t'(26'h0000010));
    bus.clear_valid = 1'b1;
    tick();
    bus.clear_valid = 1'b0;
    chk("clr_alone", word_t'(bus.class_valid), '0);
    rd(5, 3);
    chk("clr_store_kept", bus.rd_data, P01);

    // pruning mask on class 0 segment 0
`ifdef PRUNE_MASK_EN
    bus.mask_we   = 1'b1;
    bus.mask_seg  = 2'd0;
    bus.mask_data = PMK;
    tick();
    bus.mask_we   = 1'b0;
`endif
    load(0, PFF, '0, '0, '0, 0);
    rd(0, 0);
`ifdef PRUNE_MASK_EN
    chk("mask_read", bus.rd_data, PMK);
`else
    chk("nomask_read", bus.rd_data, PFF);
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
